obstacle_frame_scheduler: RTL

Per-frame sequencer for the obstacle projection pipeline (triangle creator followed by 3D projector). On each frame start it reads the frame's obstacle list from an obstacle RAM and feeds one obstacle at a time into the pipeline at a fixed spacing. It then issues the pipeline's end-of-stream done, waits for the pipeline's done, and reports frame completion together with a count of the triangles that came out.

---
 rtl/obstacle_frame_scheduler.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/obstacle_frame_scheduler.sv
// obstacle_frame_scheduler
//
// Per-frame sequencer for the obstacle projection pipeline. On an accepted
// frame start it walks the frame's obstacle list in the obstacle RAM and feeds
// one obstacle word into the pipeline every OBSTACLE_GAP cycles. After the
// last obstacle it signals end-of-stream, waits for the pipeline's done (or a
// timeout), then reports frame completion and the number of triangles seen.
//
// Ports:
//   clk_i              system clock
//   rst_i              synchronous active-high reset
//   frame_start_i      single-cycle frame request (accepted in idle only)
//   obstacle_count_i   obstacles in this frame, sampled on acceptance
//   rd_addr_o          registered obstacle RAM read address
//   rd_data_i          obstacle RAM data, valid one cycle after rd_addr_o
//   obstacle_o         obstacle word to the pipeline (held between strobes)
//   obstacle_valid_o   single-cycle strobe qualifying obstacle_o
//   proj_done_o        single-cycle end-of-stream pulse to the pipeline
//   proj_done_in_i     pipeline done
//   triangle_valid_i   pipeline triangle strobe (observed only)
//   busy_o             high from accepted frame start until frame_done_o
//   frame_done_o       single-cycle completion pulse
//   timed_out_o        with frame_done_o: completion was forced by timeout
//   triangle_count_o   triangles seen this frame, saturating
//   frame_overrun_o    sticky: frame start requested while busy
module obstacle_frame_scheduler #(
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned OBSTACLE_GAP = 40,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              frame_start_i,
  input  logic [ADDR_W:0]   obstacle_count_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [15:0]       rd_data_i,
  output logic [15:0]       obstacle_o,
  output logic              obstacle_valid_o,
  output logic              proj_done_o,
  input  logic              proj_done_in_i,
  input  logic              triangle_valid_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              timed_out_o,
  output logic [15:0]       triangle_count_o,
  output logic              frame_overrun_o
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] MaxObs = CntW'(2 ** ADDR_W);
  // FETCH + ISSUE take two cycles of every gap, so the wait between them is
  // OBSTACLE_GAP - 2 cycles (counter loaded with one less). After the last
  // obstacle the full gap elapses before FLUSH.
  localparam logic [7:0]  GapMid  = 8'(OBSTACLE_GAP - 3);
  localparam logic [7:0]  GapLast = 8'(OBSTACLE_GAP - 1);
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StGap,
    StFlush,
    StWaitDone,
    StFinish
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   n_q, n_d;
  logic [CntW-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [15:0]       obs_q, obs_d;
  logic              obs_vld_q, obs_vld_d;
  logic [7:0]        gap_q, gap_d;
  logic [15:0]       tmo_q, tmo_d;
  logic              busy_q, busy_d;
  logic              fdone_q, fdone_d;
  logic              timed_out_q, timed_out_d;
  logic [15:0]       tri_q, tri_d;
  logic              overrun_q, overrun_d;

  logic            accept;
  logic [CntW-1:0] n_clamped;
  logic [CntW-1:0] idx_inc;

  assign accept    = frame_start_i && (state_q == StIdle);
  assign n_clamped = (obstacle_count_i > MaxObs) ? MaxObs : obstacle_count_i;
  assign idx_inc   = idx_q + CntW'(1);

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    idx_d       = idx_q;
    rd_addr_d   = rd_addr_q;
    obs_d       = obs_q;
    obs_vld_d   = 1'b0;
    gap_d       = gap_q;
    tmo_d       = tmo_q;
    busy_d      = busy_q;
    fdone_d     = 1'b0;
    timed_out_d = timed_out_q;
    tri_d       = tri_q;
    overrun_d   = overrun_q;

    // Acceptance zeroes the count even if a triangle arrives the same cycle.
    if (accept) begin
      tri_d = 16'd0;
    end else if (busy_q && triangle_valid_i && (tri_q != 16'hFFFF)) begin
      tri_d = tri_q + 16'd1;
    end

    if (accept) begin
      overrun_d = 1'b0;
    end else if (frame_start_i && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          n_d         = n_clamped;
          idx_d       = '0;
          rd_addr_d   = '0;
          timed_out_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = (n_clamped == '0) ? StFlush : StFetch;
        end
      end
      // rd_addr_q already holds the index; the RAM returns data next cycle.
      StFetch: state_d = StIssue;
      StIssue: begin
        obs_d     = rd_data_i;
        obs_vld_d = 1'b1;
        idx_d     = idx_inc;
        gap_d     = (idx_inc == n_q) ? GapLast : GapMid;
        state_d   = StGap;
      end
      StGap: begin
        if (gap_q == 8'd0) begin
          if (idx_q == n_q) begin
            state_d = StFlush;
          end else begin
            rd_addr_d = idx_q[ADDR_W-1:0];
            state_d   = StFetch;
          end
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      StFlush: begin
        tmo_d   = 16'd0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        // Pipeline done takes priority over a coincident timeout.
        if (proj_done_in_i) begin
          timed_out_d = 1'b0;
          state_d     = StFinish;
        end else if (tmo_q == TmoLast) begin
          timed_out_d = 1'b1;
          state_d     = StFinish;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StFinish: begin
        fdone_d = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      n_q         <= '0;
      idx_q       <= '0;
      rd_addr_q   <= '0;
      obs_q       <= '0;
      obs_vld_q   <= 1'b0;
      gap_q       <= '0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      fdone_q     <= 1'b0;
      timed_out_q <= 1'b0;
      tri_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      rd_addr_q   <= rd_addr_d;
      obs_q       <= obs_d;
      obs_vld_q   <= obs_vld_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      fdone_q     <= fdone_d;
      timed_out_q <= timed_out_d;
      tri_q       <= tri_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rd_addr_o        = rd_addr_q;
  assign obstacle_o       = obs_q;
  assign obstacle_valid_o = obs_vld_q;
  assign proj_done_o      = (state_q == StFlush);
  assign busy_o           = busy_q;
  assign frame_done_o     = fdone_q;
  assign timed_out_o      = timed_out_q;
  assign triangle_count_o = tri_q;
  assign frame_overrun_o  = overrun_q;

endmodule
